// File: rtl/cmap_arbiter_pkg.sv
// Shared types for the colour_map arbiter: beat flags, lock FSM
// states, bubble hue constant and a saturating counter helper.
package cmap_arbiter_pkg;

  typedef struct packed {
    logic sof;
    logic eol;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } cmap_arb_state_t;

  localparam logic [10:0] CMAP_BUBBLE_HUE = 11'd2047;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        inc
  );
    if (inc && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/cmap_arbiter_watchdog.sv
// Lock watchdog: counts enabled cycles, clears on i_clr, o_tc high
// on the enabled cycle at count TIMEOUT_CYCLES-1 (never if 0).
// Ports: clk, resetn, i_clr, i_en -> o_tc.
module cmap_arbiter_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter int unsigned TIMEOUT_W      = 12
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned TCM1 =
    (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TIMEOUT_W-1:0] TC = TIMEOUT_W'(TCM1);

  logic [TIMEOUT_W-1:0] r_cnt;

  assign o_tc = (TIMEOUT_CYCLES != 0) && i_en && (r_cnt == TC);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/cmap_arbiter.sv
// Line-granular round-robin arbiter sharing colour_map between two
// pixel sources; registered output, lock watchdog. Optional stats
// counters (stats_clr, s0_beats, s1_beats, stall_cycles) under
// macro CMAP_ARB_STATS_EN.
module cmap_arbiter
  import cmap_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter int unsigned TIMEOUT_W      = 12
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [10:0] s0_hue,
  input  logic [8:0]  s0_log_mag,
  input  flags_t      s0_flags,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [10:0] s1_hue,
  input  logic [8:0]  s1_log_mag,
  input  flags_t      s1_flags,
  output logic [10:0] cm_hue,
  output logic [8:0]  cm_log_mag,
  output flags_t      cm_flags,
  output logic        cm_valid,
  input  logic        cm_ready,
`ifdef CMAP_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] s0_beats,
  output logic [31:0] s1_beats,
  output logic [31:0] stall_cycles,
`endif
  output logic        grant,
  output logic        err_timeout
);

  cmap_arb_state_t r_state, w_state_n;
  logic r_rr, w_rr_n;
  logic r_grant, r_err;
  logic [10:0] r_hue;
  logic [8:0]  r_mag;
  flags_t      r_flags;
  logic        r_valid;

  logic        w_sel, w_any, w_own;
  logic        w_acc0, w_acc1, w_acc;
  logic        w_lock_valid;
  logic        w_wd_en, w_wd_clr, w_tc;
  logic [10:0] w_hue;
  logic [8:0]  w_mag;
  flags_t      w_flags;

  // Selected source: fixed while locked, rr_ptr breaks IDLE ties.
  always_comb begin
    w_sel = 1'b0;
    w_any = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_any = s0_valid | s1_valid;
        w_sel = (s0_valid & s1_valid) ? r_rr : s1_valid;
      end
      LOCK0: begin
        w_any = 1'b1;
        w_sel = 1'b0;
      end
      LOCK1: begin
        w_any = 1'b1;
        w_sel = 1'b1;
      end
      default: begin
        w_any = 1'b0;
        w_sel = 1'b0;
      end
    endcase
  end

  assign w_own    = resetn & cm_ready & w_any;
  assign s0_ready = w_own & ~w_sel;
  assign s1_ready = w_own & w_sel;
  assign w_acc0   = s0_ready & s0_valid;
  assign w_acc1   = s1_ready & s1_valid;
  assign w_acc    = w_acc0 | w_acc1;

  assign w_hue   = w_sel ? s1_hue : s0_hue;
  assign w_mag   = w_sel ? s1_log_mag : s0_log_mag;
  assign w_flags = w_sel ? s1_flags : s0_flags;

  assign w_lock_valid = w_sel ? s1_valid : s0_valid;
  assign w_wd_en  = (r_state != IDLE) & cm_ready & ~w_lock_valid;
  assign w_wd_clr = (r_state == IDLE) | w_acc;

  cmap_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_wd (
    .clk   (clk),
    .resetn(resetn),
    .i_clr (w_wd_clr),
    .i_en  (w_wd_en),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_state_n = r_state;
    w_rr_n    = r_rr;
    if (w_tc) begin
      w_state_n = IDLE;
      w_rr_n    = ~w_sel;
    end else if (w_acc) begin
      if (w_flags.eol) begin
        w_state_n = IDLE;
        w_rr_n    = ~w_sel;
      end else begin
        w_state_n = w_sel ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_grant <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_rr    <= w_rr_n;
      r_err   <= w_tc;
      if (w_acc) r_grant <= w_sel;
    end
  end

  // Output stage holds while colour_map stalls; bubbles otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hue   <= CMAP_BUBBLE_HUE;
      r_mag   <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
    end else if (cm_ready) begin
      if (w_acc) begin
        r_hue   <= w_hue;
        r_mag   <= w_mag;
        r_flags <= w_flags;
        r_valid <= 1'b1;
      end else begin
        r_hue   <= CMAP_BUBBLE_HUE;
        r_mag   <= '0;
        r_flags <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign cm_hue      = r_hue;
  assign cm_log_mag  = r_mag;
  assign cm_flags    = r_flags;
  assign cm_valid    = r_valid;
  assign grant       = r_grant;
  assign err_timeout = r_err;

`ifdef CMAP_ARB_STATS_EN
  logic [31:0] r_s0_beats, r_s1_beats, r_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s0_beats <= '0;
      r_s1_beats <= '0;
      r_stall    <= '0;
    end else if (stats_clr) begin
      r_s0_beats <= '0;
      r_s1_beats <= '0;
      r_stall    <= '0;
    end else begin
      r_s0_beats <= sat_inc(r_s0_beats, w_acc0);
      r_s1_beats <= sat_inc(r_s1_beats, w_acc1);
      r_stall    <= sat_inc(r_stall, ~cm_ready);
    end
  end

  assign s0_beats     = r_s0_beats;
  assign s1_beats     = r_s1_beats;
  assign stall_cycles = r_stall;
`endif

endmodule

// File: doc/cmap_arbiter.md
Name: cmap_arbiter

Overview:
Shares one colour_map pixel pipeline between two pixel-stream requesters, for example the spectrogram renderer and the overlay/UI renderer. Arbitration is round-robin at line granularity: once a source wins, it keeps the grant until it sends a beat with flags.eol. The block registers the selected beat into colour_map's hue/log_mag/flags inputs and obeys colour_map's in_ready backpressure. A lock watchdog releases a grant if the owning source stalls mid-line.

Parameters:
TIMEOUT_CYCLES, 2048, number of idle cycles of the locked source (with cm_ready high) before the lock is forcibly released; 0 disables the watchdog.
TIMEOUT_W, 12, width of the watchdog counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock; all state changes on rising edge
resetn  in  1  reset, asynchronous, active-low
s0_valid  in  1  source 0 beat valid
s0_ready  out  1  source 0 beat accepted this cycle when high together with s0_valid
s0_hue  in  11  source 0 hue, 0–1535
s0_log_mag  in  9  source 0 brightness
s0_flags  in  flags_t  source 0 flags (sof, eol)
s1_valid / s1_ready / s1_hue / s1_log_mag / s1_flags  same as s0_*, for source 1
cm_hue  out  11  to colour_map hue
cm_log_mag  out  9  to colour_map log_mag
cm_flags  out  flags_t  to colour_map flags_in
cm_valid  out  1  high when the registered beat is real data, low for a bubble
cm_ready  in  1  from colour_map in_ready
grant  out  1  index of the current or last owner
err_timeout  out  1  one-cycle pulse when the watchdog releases a lock

Behaviour:
- Reset (resetn low, async):
  - state=IDLE, rr_ptr=0, watchdog=0.
  - cm_hue=CMAP_BUBBLE_HUE (11'd2047), cm_log_mag=0, cm_flags=0, cm_valid=0.
  - grant=0, err_timeout=0.
  - s0_ready=s1_ready=0, forced while resetn is low.
- sN_ready is combinational: cm_ready AND (source N is granted this cycle). Never both high.
- States:
  - IDLE, no owner. If both sources are valid, rr_ptr wins. If one is valid, it wins. The winning beat is accepted in the same cycle.
  - IDLE exit: accepted beat has eol → stay IDLE, rr_ptr=other. Otherwise → LOCK0 or LOCK1; grant=winner.
  - LOCKn: only source n is ready. An accepted beat with eol → IDLE, rr_ptr=other. Other beats stay in LOCKn.
- Watchdog (LOCKn only):
  - Increments on cycles with cm_ready high and sn_valid low; clears on every accepted beat and on leaving LOCKn.
  - On reaching TIMEOUT_CYCLES-1 → IDLE, rr_ptr=other, err_timeout=1 for the next cycle only.
  - The partial line is not repaired downstream.
- Output register (latency 1 cycle from acceptance):
  - cm_ready high, beat accepted → load hue/log_mag/flags, cm_valid=1.
  - cm_ready high, no beat → load bubble: hue=2047, log_mag=0, flags=0, cm_valid=0.
  - cm_ready low → hold all cm_* outputs. No acceptance and no state change; the watchdog holds.
- Data passes through unmodified, including source hue >1535; colour_map renders that as white with flags cleared.
- A sof beat arriving while the other source is locked waits; there is no pre-emption.
- A beat carrying both sof and eol is a one-beat line; the state returns to IDLE.

Optional Feature:
CMAP_ARB_STATS_EN defined:
- Adds inputs stats_clr (1) and outputs s0_beats (32), s1_beats (32), stall_cycles (32).
- s0_beats and s1_beats count accepted beats; stall_cycles counts cm_ready-low cycles.
- All counters are saturating at 32'hFFFF_FFFF, cleared by reset or by stats_clr. If stats_clr and an increment occur together, the result is 0.

CMAP_ARB_STATS_EN undefined: these ports and counters do not exist.

Decomposition:
- types_pkg additions:
  - cmap_arb_state_t enum {IDLE, LOCK0, LOCK1}.
  - localparam CMAP_BUBBLE_HUE = 11'd2047.
  - flags_t reused as is.
- Sub-module cmap_arb_watchdog: counter with clear, enable and terminal-count pulse, parameterised by TIMEOUT_CYCLES/TIMEOUT_W.

Test Plan:
- Alternating lines: both sources send 4-beat lines (eol on beat 4), cm_ready=1 → output order is s0 ×4, s1 ×4, s0 ×4; cm_valid=1 throughout, one cycle after each acceptance.
- Lock hold: s0 locked after 2 beats, s1_valid=1 continuously → s1_ready stays 0 until s0's eol beat is accepted; s1's first beat appears on the next cycle.
- Backpressure: cm_ready=0 for 5 cycles mid-line → cm_* outputs frozen, sN_ready=0, stall_cycles +5 (with STATS_EN); data resumes unchanged.
- Watchdog: TIMEOUT_CYCLES=8, s0 locked then s0_valid=0 → err_timeout pulses after 8 idle cycles; a pending s1 beat is granted next.
- Bubble/idle: no valid input → cm_hue=2047, cm_log_mag=0, cm_flags=0, cm_valid=0.
- Async reset mid-line (resetn low for 1 cycle) → immediate bubble outputs, state=IDLE, rr_ptr=0; a fresh s1 line is then accepted normally.
